// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial add/sub stage.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Width of the shift counter for a given operand width.
   // It must count 0..WIDTH inclusive, plus one bit of headroom.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1) + 1;
   endfunction

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/fa.sv
// Single one-bit full-adder cell.
module fa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sout,
   output logic cout
);

   // Sum and carry of three one-bit inputs.
   always_comb begin
      sout = a ^ b ^ c;
      cout = (a & b) | (a & c) | (b & c);
   end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial signed adder/subtractor.
// Operands stream LSB-first through one full-adder cell. One extra shift over
// the sign-extended MSBs makes the WIDTH+1-bit result exact.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             ovf
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH:0]   r_q, r_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic fa_sout;
   logic fa_cout;

   fa u_fa (
      .a    (sa_q[0]),
      .b    (sb_q[0]),
      .c    (carry_q),
      .sout (fa_sout),
      .cout (fa_cout)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      r_d     = r_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sa_d    = a;
               // Subtraction is A + ~B + 1: invert B here, the +1 enters as carry-in.
               sb_d    = b ^ {WIDTH{sub}};
               carry_d = sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Arithmetic shift keeps presenting the sign bit after the last real bit.
            sa_d    = {sa_q[WIDTH-1], sa_q[WIDTH-1:1]};
            sb_d    = {sb_q[WIDTH-1], sb_q[WIDTH-1:1]};
            r_d     = {fa_sout, r_q[WIDTH:1]};
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         r_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         r_q     <= r_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake and result outputs.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      sum       = r_q;
      ovf       = r_q[WIDTH] ^ r_q[WIDTH-1];
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_serial_addsub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W:0]   sum;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 busy, 2 result ready.
   bit         m_init  = 1'b0;
   int         m_ph    = 0;
   int         m_wait  = 0;
   bit         m_clean = 1'b0;
   logic [W:0] m_sum;
   logic       m_ovf;

   always @(posedge clk) begin
      if (rst) begin
         m_init  = 1'b1;
         m_ph    = 0;
         m_clean = 1'b1;
      end else if (m_init) begin
         case (m_ph)
            0: if (in_valid) begin
               int av, bv, res;
               av      = $signed(a);
               bv      = $signed(b);
               res     = sub ? av - bv : av + bv;
               m_sum   = res[W:0];
               m_ovf   = (res > 127) || (res < -128);
               m_wait  = W + 1;
               m_ph    = 1;
               m_clean = 1'b0;
            end
            1: begin
               m_wait--;
               if (m_wait == 0) m_ph = 2;
            end
            default: if (out_ready) m_ph = 0;
         endcase
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (m_init) begin
         chk("m_in_ready", in_ready, m_ph == 0);
         chk("m_out_valid", out_valid, m_ph == 2);
         if (m_ph == 2) begin
            chk("m_sum", sum, m_sum);
            chk("m_ovf", ovf, m_ovf);
         end else if (m_ph == 0 && m_clean) begin
            chk("m_rst_sum", sum, 0);
            chk("m_rst_ovf", ovf, 0);
         end
      end
   end

   // Present one operation, wait for the result, check latency and values,
   // hold backpressure for 'hold' cycles, then complete the handshake.
   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                     input int hold, input logic [W:0] es, input logic eo, input string nm);
      int cyc;
      int g;
      logic [W:0] held;
      g = 0;
      while (!in_ready && g < 40) begin
         @(negedge clk);
         g++;
      end
      chk({nm, "_in_ready"}, in_ready, 1);
      a = x; b = y; sub = s; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      cyc = 0;
      while (!out_valid && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_latency"}, cyc, W + 1);
      chk({nm, "_sum"}, sum, es);
      chk({nm, "_ovf"}, ovf, eo);
      held = sum;
      for (int i = 0; i < hold; i++) begin
         in_valid = (i == 2);
         @(negedge clk);
         chk({nm, "_hold_valid"}, out_valid, 1);
         chk({nm, "_hold_sum"}, sum, held);
         chk({nm, "_hold_ovf"}, ovf, eo);
         chk({nm, "_hold_in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, "_next_in_ready"}, in_ready, 1);
      chk({nm, "_next_out_valid"}, out_valid, 0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 8'h80;
         1: return 8'h7F;
         2: return 8'hFF;
         3: return 8'h00;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sum", sum, 0);
      chk("reset_ovf", ovf, 0);

      op(8'd100, 8'd27, 1'b0, 0, 9'h07F, 1'b0, "add_127");
      op(8'd100, 8'd28, 1'b0, 0, 9'h080, 1'b1, "add_128");
      op(8'h80, 8'h01, 1'b1, 0, 9'h17F, 1'b1, "sub_m129");
      op(8'd5, 8'd7, 1'b1, 0, 9'h1FE, 1'b0, "sub_m2");
      // Issued immediately in the cycle after the result handshake.
      op(8'hFF, 8'hFF, 1'b0, 5, 9'h1FE, 1'b0, "bp_m1m1");

      // Reset during RUN discards the operation.
      a = 8'd50; b = 8'd60; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrun_rst_in_ready", in_ready, 1);
      chk("midrun_rst_out_valid", out_valid, 0);
      chk("midrun_rst_sum", sum, 0);
      op(8'd3, 8'd4, 1'b0, 0, 9'h007, 1'b0, "after_rst");

      // Randomized traffic, checked by the model.
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         a         = pick();
         b         = pick();
         sub       = 1'($urandom);
         @(negedge clk);
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
